// File: rtl/randomizer_pkg.sv
// randomizer_pkg: shared frame/seed constants and controller state encoding.
package randomizer_pkg;
  localparam int FRAME_LEN = 96;
  localparam int SEED_W = 15;
  localparam logic [SEED_W-1:0] DEFAULT_SEED = 15'h3715;
  localparam int CNT_W = $clog2(FRAME_LEN);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} ctrl_state_t;
endpackage

// File: rtl/randomizer.sv
// randomizer: serial 1+x^14+x^15 scrambler; seed[SEED_W-1] is the first LFSR stage.
module randomizer
  import randomizer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [SEED_W-1:0] seed,
  input  logic              din,
  output logic              dout
);
  logic [SEED_W-1:0] s;
  logic prbs;
  assign prbs = s[1] ^ s[0];
  assign dout = din ^ prbs;
  always_ff @(posedge clk) begin
    if (reset) s <= DEFAULT_SEED;
    else if (load) s <= seed;
    else if (en) s <= {prbs, s[SEED_W-1:1]};
  end
endmodule

// File: rtl/randomizer_ctrl.sv
// randomizer_ctrl: frame sequencer that loads the seed, gates the external
// randomizer per accepted bit and registers the result into a valid/ready stream.
module randomizer_ctrl
  import randomizer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SEED_W-1:0] cfg_seed,
  input  logic              cfg_seed_we,
  input  logic              cfg_bypass,
  input  logic              in_valid,
  input  logic              in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy,
  output logic              rand_din,
  output logic              rand_load,
  output logic              rand_en,
  output logic [SEED_W-1:0] rand_seed,
  output logic              rand_reset,
  input  logic              rand_dout
);
  ctrl_state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [SEED_W-1:0] seed_reg;
  logic bypass_q, acc, fin;
  assign acc = in_valid && in_ready;
  assign fin = acc && cnt == CNT_W'(FRAME_LEN - 1);
  assign rand_reset = reset;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state == IDLE ? (in_valid ? LOAD : IDLE) :
           state == LOAD ? RUN :
           state == RUN  ? (fin ? DONE : RUN) : IDLE;
  end
  always_comb begin
    in_ready = state == RUN && (!out_valid || out_ready);
    rand_load = state == LOAD;
    rand_en = acc && !bypass_q;
    rand_din = acc && in_data;
    frame_done = state == DONE;
    busy = state != IDLE;
  end
  // rand_seed doubles as the frame-latched seed so mid-frame writes wait for the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      seed_reg <= DEFAULT_SEED;
      rand_seed <= DEFAULT_SEED;
      bypass_q <= 1'b0;
      out_valid <= 1'b0;
      out_data <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (cfg_seed_we) seed_reg <= cfg_seed;
      if (state == IDLE && in_valid) begin
        rand_seed <= seed_reg;
        bypass_q <= cfg_bypass;
      end
      if (acc) begin
        out_valid <= 1'b1;
        out_data <= bypass_q ? in_data : rand_dout;
        out_last <= fin;
        cnt <= fin ? '0 : cnt + 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_randomizer_ctrl.sv
// tb_randomizer_ctrl: directed frame vectors against the controller driving the serial randomizer.
module tb_randomizer_ctrl;
  localparam logic [95:0] D = 96'hACBCD2114DAE1577C6DBF4C9;
  localparam logic [95:0] R = 96'h558AC4A53A1724E163AC2BF9;
  logic clk = 0, reset = 1;
  logic [14:0] cfg_seed = 15'h3715;
  logic cfg_seed_we = 0, cfg_bypass = 0, in_valid = 0, in_data = 0, out_ready = 1;
  logic in_ready, out_valid, out_data, out_last, frame_done, busy;
  logic rand_din, rand_load, rand_en, rand_reset, rand_dout;
  logic [14:0] rand_seed;
  int ncmp = 0, nfail = 0, cyc = 0;
  int nout, nlast, last_pos, ndone, nload, nen, nbad, nhold, nacc, load_cyc;
  int acc_cyc [256];
  logic [14:0] load_seed;
  logic [191:0] cap;
  logic pv = 0, pr = 0, pd = 0, pl = 0, tog = 0;
  int ph = 0;

  randomizer_ctrl dut (.clk(clk), .reset(reset), .cfg_seed(cfg_seed), .cfg_seed_we(cfg_seed_we),
    .cfg_bypass(cfg_bypass), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .frame_done(frame_done), .busy(busy), .rand_din(rand_din), .rand_load(rand_load),
    .rand_en(rand_en), .rand_seed(rand_seed), .rand_reset(rand_reset), .rand_dout(rand_dout));
  randomizer u_rand (.clk(clk), .reset(rand_reset), .load(rand_load), .en(rand_en),
    .seed(rand_seed), .din(rand_din), .dout(rand_dout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      cap = {cap[190:0], out_data};
      if (out_last) begin nlast++; last_pos = nout; end
      nout++;
    end
    if (in_valid && in_ready) begin
      if (nacc < 256) acc_cyc[nacc] = cyc;
      nacc++;
    end
    if (rand_en) nen++;
    if (rand_en && !(in_valid && in_ready)) nbad++;
    if (rand_load) begin nload++; load_cyc = cyc; load_seed = rand_seed; end
    if (frame_done) ndone++;
    if (!reset && pv && !pr && (!out_valid || out_data != pd || out_last != pl)) nhold++;
    pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 3;
      out_ready = tog ? (ph == 0) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [95:0] model(input logic [14:0] sd, input logic [95:0] d);
    logic [14:0] s = sd;
    logic [95:0] r = '0;
    logic p;
    for (int i = 0; i < 96; i++) begin
      p = s[1] ^ s[0];
      r[95-i] = d[95-i] ^ p;
      s = {p, s[14:1]};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    repeat (3) @(posedge clk);
    #1;
    nout = 0; nlast = 0; last_pos = -1; ndone = 0; nload = 0; nen = 0;
    nbad = 0; nhold = 0; nacc = 0; load_cyc = -100; cap = '0;
  endtask

  task automatic send(input logic [95:0] d, input bit hold, input int we_at, input int abort_at);
    int t;
    for (int i = 0; i < 96; i++) begin
      if (i == abort_at) return;
      in_valid = 1; in_data = d[95-i];
      if (i == we_at) begin cfg_seed = 15'h7FFF; cfg_seed_we = 1; end
      t = 0;
      do begin @(negedge clk); t++; end while (!in_ready && t < 200);
      if (!in_ready) begin
        chk("accept_timeout", 0, 1);
        in_valid = 0;
        return;
      end
      @(posedge clk); #1;
      cfg_seed_we = 0;
    end
    if (!hold) in_valid = 0;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (nout < n && t < 50) begin @(posedge clk); t++; end
    #1;
    chk("out_count", nout, n);
  endtask

  typedef struct { logic byp; logic tg; logic [95:0] din; logic [95:0] dout; } vec_t;
  vec_t vt [4];

  initial begin
    vt[0] = '{1'b0, 1'b0, D, R};
    vt[1] = '{1'b0, 1'b1, D, R};
    vt[2] = '{1'b1, 1'b0, D, D};
    vt[3] = '{1'b1, 1'b1, D, D};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_done, rand_load, rand_en, out_last, out_data}, 0);
    chk("rst_seed", rand_seed, 15'h3715);
    chk("rst_rand_reset", rand_reset, 1);
    @(posedge clk); #1 reset = 0;
    #1 chk("rand_reset_low", rand_reset, 0);

    for (int v = 0; v < 4; v++) begin
      clr();
      cfg_bypass = vt[v].byp; tog = vt[v].tg;
      send(vt[v].din, 0, -1, -1);
      drain(96);
      tog = 0;
      chk("out_word", cap[95:0], vt[v].dout);
      chk("last_count", nlast, 1);
      chk("last_pos", last_pos, 95);
      chk("done_pulses", ndone, 1);
      chk("load_pulses", nload, 1);
      chk("en_pulses", nen, vt[v].byp ? 0 : 96);
      chk("load_to_first", acc_cyc[0] - load_cyc, 1);
      chk("en_wo_accept", nbad, 0);
      chk("hold_stable", nhold, 0);
    end
    cfg_bypass = 0;

    clr();
    send(D, 0, 40, -1);
    drain(96);
    chk("f1_word", cap[95:0], R);
    chk("f1_load_seed", load_seed, 15'h3715);
    chk("f1_seed_after", rand_seed, 15'h3715);
    clr();
    send(D, 0, -1, -1);
    drain(96);
    chk("f2_load_seed", load_seed, 15'h7FFF);
    chk("f2_seed_show", rand_seed, 15'h7FFF);
    chk("f2_word", cap[95:0], model(15'h7FFF, D));
    cfg_seed = 15'h3715; cfg_seed_we = 1;
    @(posedge clk); #1 cfg_seed_we = 0;

    clr();
    send(D, 0, -1, 50);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    #1 reset = 1; in_valid = 0;
    #1 chk("mid_rand_reset", rand_reset, 1);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    clr();
    send(D, 0, -1, -1);
    drain(96);
    chk("post_rst_word", cap[95:0], R);
    chk("post_rst_last", last_pos, 95);

    clr();
    send(D, 1, -1, -1);
    send(D, 0, -1, -1);
    drain(192);
    chk("b2b_f1", cap[191:96], R);
    chk("b2b_f2", cap[95:0], R);
    chk("b2b_gap", acc_cyc[96] - acc_cyc[95], 4);
    chk("b2b_done", ndone, 2);
    chk("b2b_last", nlast, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
